// File: rtl/spi_pkt_controller.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkt_controller
// Function : Decodes SPI byte packets into synth divider writes, IQ FIFO
//            bursts and status readback (FIFO space, drop/error counters).
// Revision : 1.0 - initial release
// ============================================================================
module spi_pkt_controller #(
   parameter int         FIFO_AW   = 12,
   parameter int         N_SYNTH   = 2,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   localparam int        C_SEL_W   = $clog2((N_SYNTH < 2) ? 2 : N_SYNTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         spi_c_data_in,
   input  logic               spi_c_data_stb,
   input  logic               spi_tsx_start,
   output logic [7:0]         spi_c_data_out,
   input  logic [FIFO_AW-1:0] fifo_space_free,
   input  logic               fifo_full,
   output logic [7:0]         fifo_data_in,
   output logic               fifo_wr,
   output logic [7:0]         freq_data,
   output logic [C_SEL_W-1:0] freq_sel,
   output logic               freq_wr_divr,
   output logic               freq_wr_divf,
   output logic               pkt_err
);

   localparam int         C_SPACE_BYTES = (FIFO_AW + 7) / 8;
   localparam int         C_SPACE_W     = 8 * C_SPACE_BYTES;
   localparam logic [7:0] C_LAST_SPACE  = 8'(C_SPACE_BYTES - 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_TYPE  = 4'd1,
      S_LEN   = 4'd2,
      S_SPACE = 4'd3,
      S_CHAN  = 4'd4,
      S_DIVR  = 4'd5,
      S_DIVF  = 4'd6,
      S_DATA  = 4'd7,
      S_STAT  = 4'd8
   } state_t;

   state_t               r_state, w_state;
   logic [7:0]           r_type, w_type;
   logic [7:0]           r_rem, w_rem;
   logic [C_SEL_W-1:0]   r_chan, w_chan;
   logic                 r_bad, w_bad;
   logic [C_SPACE_W-1:0] r_space, w_space;
   logic [7:0]           r_idx, w_idx;
   logic [7:0]           r_drop_cnt, w_drop_cnt;
   logic [7:0]           r_err_cnt, w_err_cnt;
   logic [7:0]           r_data_out, w_data_out;
   logic [7:0]           r_fifo_data, w_fifo_data;
   logic                 r_fifo_wr, w_fifo_wr;
   logic [7:0]           r_freq_data, w_freq_data;
   logic [C_SEL_W-1:0]   r_freq_sel, w_freq_sel;
   logic                 r_divr, w_divr;
   logic                 r_divf, w_divf;
   logic                 r_pkt_err, w_pkt_err;
   logic [C_SPACE_W-1:0] w_space_ext;

   assign w_space_ext = C_SPACE_W'(fifo_space_free);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      w_state     = r_state;
      w_type      = r_type;
      w_rem       = r_rem;
      w_chan      = r_chan;
      w_bad       = r_bad;
      w_space     = r_space;
      w_idx       = r_idx;
      w_drop_cnt  = r_drop_cnt;
      w_err_cnt   = r_err_cnt;
      w_data_out  = r_data_out;
      w_fifo_data = r_fifo_data;
      w_freq_data = r_freq_data;
      w_freq_sel  = r_freq_sel;
      w_fifo_wr   = 1'b0;
      w_divr      = 1'b0;
      w_divf      = 1'b0;
      w_pkt_err   = 1'b0;

      // A new transaction always wins, even over a coincident strobe.
      if (spi_tsx_start) begin
         w_state    = S_TYPE;
         w_data_out = SYNC_BYTE;
         if (r_state != S_IDLE) begin
            w_pkt_err = 1'b1;
            w_err_cnt = sat_inc(r_err_cnt);
         end
      end else if (spi_c_data_stb) begin
         case (r_state)
            S_TYPE: begin
               w_type  = spi_c_data_in;
               w_state = S_LEN;
            end
            S_LEN: begin
               w_idx = 8'd0;
               case (r_type)
                  8'd0: begin
                     w_state    = S_SPACE;
                     w_space    = w_space_ext << 8;
                     w_data_out = w_space_ext[C_SPACE_W-1 -: 8];
                  end
                  8'd1: w_state = S_CHAN;
                  8'd2: begin
                     w_rem   = spi_c_data_in;
                     w_state = (spi_c_data_in == 8'd0) ? S_IDLE : S_DATA;
                  end
                  8'd3: begin
                     w_state    = S_STAT;
                     w_data_out = r_drop_cnt;
                  end
                  default: begin
                     w_state   = S_IDLE;
                     w_pkt_err = 1'b1;
                     w_err_cnt = sat_inc(r_err_cnt);
                  end
               endcase
            end
            S_SPACE: begin
               w_idx = r_idx + 8'd1;
               if (r_idx == C_LAST_SPACE) begin
                  w_state = S_IDLE;
               end else begin
                  w_data_out = r_space[C_SPACE_W-1 -: 8];
                  w_space    = r_space << 8;
               end
            end
            S_CHAN: begin
               w_chan  = spi_c_data_in[C_SEL_W-1:0];
               w_bad   = (spi_c_data_in >= 8'(N_SYNTH));
               w_state = S_DIVR;
               if (spi_c_data_in >= 8'(N_SYNTH)) begin
                  w_pkt_err = 1'b1;
                  w_err_cnt = sat_inc(r_err_cnt);
               end
            end
            S_DIVR: begin
               w_freq_data = spi_c_data_in;
               w_freq_sel  = r_chan;
               w_divr      = !r_bad;
               w_state     = S_DIVF;
            end
            S_DIVF: begin
               w_freq_data = spi_c_data_in;
               w_freq_sel  = r_chan;
               w_divf      = !r_bad;
               w_state     = S_IDLE;
            end
            S_DATA: begin
               w_rem      = r_rem - 8'd1;
               w_data_out = w_space_ext[7:0];
               if (!fifo_full) begin
                  w_fifo_data = spi_c_data_in;
                  w_fifo_wr   = 1'b1;
               end else begin
                  w_drop_cnt = sat_inc(r_drop_cnt);
               end
               if (r_rem == 8'd1) begin
                  w_state = S_IDLE;
               end
            end
            S_STAT: begin
               if (r_idx == 8'd0) begin
                  w_data_out = r_err_cnt;
                  w_idx      = 8'd1;
               end else begin
                  w_drop_cnt = 8'd0;
                  w_err_cnt  = 8'd0;
                  w_state    = S_IDLE;
               end
            end
            default: begin
               w_state = r_state;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_type      <= 8'd0;
         r_rem       <= 8'd0;
         r_chan      <= '0;
         r_bad       <= 1'b0;
         r_space     <= '0;
         r_idx       <= 8'd0;
         r_drop_cnt  <= 8'd0;
         r_err_cnt   <= 8'd0;
         r_data_out  <= 8'd0;
         r_fifo_data <= 8'd0;
         r_fifo_wr   <= 1'b0;
         r_freq_data <= 8'd0;
         r_freq_sel  <= '0;
         r_divr      <= 1'b0;
         r_divf      <= 1'b0;
         r_pkt_err   <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_type      <= w_type;
         r_rem       <= w_rem;
         r_chan      <= w_chan;
         r_bad       <= w_bad;
         r_space     <= w_space;
         r_idx       <= w_idx;
         r_drop_cnt  <= w_drop_cnt;
         r_err_cnt   <= w_err_cnt;
         r_data_out  <= w_data_out;
         r_fifo_data <= w_fifo_data;
         r_fifo_wr   <= w_fifo_wr;
         r_freq_data <= w_freq_data;
         r_freq_sel  <= w_freq_sel;
         r_divr      <= w_divr;
         r_divf      <= w_divf;
         r_pkt_err   <= w_pkt_err;
      end
   end

   assign spi_c_data_out = r_data_out;
   assign fifo_data_in   = r_fifo_data;
   assign fifo_wr        = r_fifo_wr;
   assign freq_data      = r_freq_data;
   assign freq_sel       = r_freq_sel;
   assign freq_wr_divr   = r_divr;
   assign freq_wr_divf   = r_divf;
   assign pkt_err        = r_pkt_err;

endmodule
`default_nettype wire

// File: doc/spi_pkt_controller.md
Name: spi_pkt_controller

Overview:
- Parametrised successor to the SPI command controller.
- Decodes byte packets arriving from the SPI slave and drives N_SYNTH frequency-synthesiser divider ports and the IQ sample FIFO write port.
- Returns FIFO free-space and error/drop status over SPI.
- Adds four things: multi-channel synth addressing, exact-length FIFO bursts with drop counting, packet abort on a new transaction, and a status readback packet.

Parameters:
FIFO_AW, 12, width of fifo_space_free; readback uses SPACE_BYTES = ceil(FIFO_AW/8) bytes.
N_SYNTH, 2, number of synthesiser channels (1..16).
SYNC_BYTE, 8'hA5, byte presented on spi_c_data_out at transaction start.

Ports:
clk  in  1  clock
rst  in  1  reset
spi_c_data_in  in  8  received byte, valid when spi_c_data_stb
spi_c_data_stb  in  1  one-cycle strobe per received byte; at most 1 in any 3 cycles
spi_tsx_start  in  1  one-cycle pulse at chip-select assertion
spi_c_data_out  out  8  byte to shift out on the next SPI byte
fifo_space_free  in  FIFO_AW  free words in the IQ FIFO
fifo_full  in  1  IQ FIFO full
fifo_data_in  out  8  FIFO write data
fifo_wr  out  1  FIFO write pulse
freq_data  out  8  divider value
freq_sel  out  clog2(max(N_SYNTH,2))  target synth channel
freq_wr_divr  out  1  divr write pulse
freq_wr_divf  out  1  divf write pulse
pkt_err  out  1  one-cycle pulse on any framing or packet error

Behaviour:
Interface:
- Single clock `clk`.
- Reset `rst` is synchronous and active-high.
- All outputs are registered.

Reset:
- All outputs 0; state IDLE; drop_cnt and err_cnt 0.
- Reset mid-packet aborts the packet immediately; no pulse is emitted in the reset cycle.

Pulses:
- fifo_wr, freq_wr_divr, freq_wr_divf and pkt_err are single-cycle.
- Each asserts the cycle after the strobe that causes it and defaults to 0 otherwise.

States:
- IDLE: on spi_tsx_start -> TYPE; spi_c_data_out <= SYNC_BYTE.
- TYPE: on strobe, latch type -> LEN.
- LEN: on strobe, latch len (8 b).
  - type 0 -> SPACE.
  - type 1 -> CHAN.
  - type 2 -> DATA, or IDLE if len==0.
  - type 3 -> STAT.
  - type >3 -> IDLE with pkt_err and err_cnt+1.
- SPACE: on entry, snapshot fifo_space_free (zero-extended to 8*SPACE_BYTES). spi_c_data_out presents the snapshot MSB byte first. Each strobe advances one byte; the strobe consuming the last byte -> IDLE.
- CHAN: on strobe, latch channel.
  - If channel >= N_SYNTH: set bad flag, pkt_err, err_cnt+1.
  - -> DIVR.
- DIVR: on strobe, freq_data <= byte, freq_sel <= channel, freq_wr_divr pulses unless bad -> DIVF.
- DIVF: same with freq_wr_divf -> IDLE. The len byte is ignored for type 1.
- DATA: each strobe consumes one byte; remaining decrements.
  - If !fifo_full: fifo_data_in <= byte, fifo_wr pulses.
  - Else: the byte is dropped and drop_cnt+1. fifo_wr must never assert when fifo_full was high at the strobe cycle.
  - After each strobe, spi_c_data_out <= fifo_space_free[7:0].
  - Exactly len bytes are consumed, then -> IDLE.
- STAT: present drop_cnt, then err_cnt, on spi_c_data_out. The strobe consuming the second byte clears both counters -> IDLE.
  - No increment source is active in STAT, so there is no clear/increment collision.

Abort:
- spi_tsx_start in any non-IDLE state restarts at TYPE: SYNC_BYTE is re-presented, pkt_err pulses, err_cnt+1.
- If start and strobe coincide, start wins and the strobe is ignored.

Counters:
- drop_cnt and err_cnt are 8-bit and saturate at 8'hFF.
- Strobes received in IDLE are ignored.

Test Plan:
- start, bytes 02,03,11,22,33 with fifo_full=0 -> fifo_wr pulses three times with data 11,22,33; IDLE after third byte; no pkt_err.
- Same packet with fifo_full=1 during byte 22 -> writes 11,33 only; then type 03 readback -> bytes 01,00; a second readback -> 00,00.
- FIFO_AW=12, fifo_space_free=12'hABC, packet 00,00 -> spi_c_data_out 0A then BC; IDLE after second strobe.
- packet 01,00,01,05,07 with N_SYNTH=2 -> freq_sel=1; divr pulse with data 05, then divf pulse with data 07. Same with channel 02 -> no write pulses, pkt_err once, err_cnt=1.
- start, 02,05,AA, then start again -> pkt_err, state TYPE, SYNC_BYTE presented; one fifo_wr only; the following 02,00 packet returns to IDLE without writes.
- type 07 -> IDLE plus pkt_err. Assert rst mid-DATA -> all outputs 0 next cycle; no further fifo_wr.
